// File: rtl/rv32i_types.sv
// Shared types for the data-memory responder: FSM state encoding, LFSR seed
// and the latched write-request payload.
package rv32i_types;

   localparam int unsigned DMEM_DATA_W = 32;
   localparam int unsigned DMEM_BE_W   = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } dmem_resp_state_t;

   localparam logic [7:0] LFSR_SEED = 8'hA5;

   // Request fields captured at acceptance and replayed at completion
   typedef struct packed {
      logic [DMEM_BE_W-1:0]   be;
      logic [DMEM_DATA_W-1:0] wdata;
      logic                   write;
   } dmem_wreq_t;

endpackage

// File: rtl/dmem_responder_lfsr8.sv
// 8-bit Galois LFSR (taps 8,6,5,4) that steps once per accepted request.
// Only compiled when DMEM_RESPONDER_RAND_LATENCY_EN is defined.
`ifdef DMEM_RESPONDER_RAND_LATENCY_EN
module lfsr8
   import rv32i_types::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       step_i,
   output logic [7:0] value_o
);

   logic [7:0] lfsr_q;
   logic [7:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (step_i) begin
         lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign value_o = lfsr_q;

endmodule
`endif

// File: rtl/dmem_responder.sv
// Word-addressed data memory with an IDLE/BUSY/DONE handshake and fixed latency.
// Define DMEM_RESPONDER_RAND_LATENCY_EN to add 0..3 random extra BUSY cycles.
module dmem_responder
   import rv32i_types::*;
#(
   parameter int unsigned LATENCY    = 2,
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dmem_read,
   input  logic        dmem_write,
   input  logic [31:0] dmem_address,
   input  logic [3:0]  dmem_byte_enable,
   input  logic [31:0] dmem_wdata,
   input  logic        dmem_stall,
   output logic        dmem_resp,
   output logic        dmem_ready,
   output logic [31:0] dmem_rdata
);

   localparam int unsigned CNT_W = 5;
   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   dmem_resp_state_t        state_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [ADDR_WIDTH-1:0]   idx_q;
   dmem_wreq_t              req_q;
   logic                    ready_q;
   logic [DMEM_DATA_W-1:0]  rdata_q;
   logic [DMEM_DATA_W-1:0]  mem_q [DEPTH];

   logic                    req_c;
   logic                    accept_c;
   logic                    complete_c;
   logic [CNT_W-1:0]        lat_c;
   logic [ADDR_WIDTH-1:0]   idx_c;
   dmem_wreq_t              cur_c;
   logic                    unused_addr_c;

   assign unused_addr_c = ^dmem_address;
   assign req_c         = dmem_read | dmem_write;
   assign accept_c      = !rst && (state_q == IDLE) && req_c;

`ifdef DMEM_RESPONDER_RAND_LATENCY_EN
   logic [7:0] lfsr_c;
   logic       unused_lfsr_c;

   lfsr8 u_lfsr8 (
      .clk     (clk),
      .rst     (rst),
      .step_i  (accept_c),
      .value_o (lfsr_c)
   );

   assign unused_lfsr_c = ^lfsr_c[7:2];
   assign lat_c         = CNT_W'(LATENCY) + CNT_W'(lfsr_c[1:0]);
`else
   assign lat_c = CNT_W'(LATENCY);
`endif

   // Completing request comes straight from the ports on a zero-latency accept
   always_comb begin
      cur_c = req_q;
      idx_c = idx_q;
      if (state_q == IDLE) begin
         cur_c.be    = dmem_byte_enable;
         cur_c.wdata = dmem_wdata;
         cur_c.write = dmem_write;
         idx_c       = dmem_address[ADDR_WIDTH+1:2];
      end
   end

   assign complete_c = !rst && ((accept_c && (lat_c == '0)) ||
                                ((state_q == BUSY) && (cnt_q == CNT_W'(1))));

   assign dmem_resp  = (rst || (state_q == IDLE)) ? ~req_c : (state_q == DONE);
   assign dmem_ready = ready_q;
   assign dmem_rdata = rdata_q;

   // Memory is deliberately left out of reset
   always_ff @(posedge clk) begin
      if (complete_c && cur_c.write) begin
         for (int b = 0; b < int'(DMEM_BE_W); b++) begin
            if (cur_c.be[b]) begin
               mem_q[idx_c][8*b +: 8] <= cur_c.wdata[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         req_q   <= '0;
         ready_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_c) begin
                  req_q   <= cur_c;
                  idx_q   <= idx_c;
                  cnt_q   <= lat_c;
                  ready_q <= 1'b0;
                  state_q <= (lat_c == '0) ? DONE : BUSY;
               end
            end
            BUSY: begin
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (!dmem_stall) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
         // Reads (write has priority over simultaneous read) publish data here
         if (complete_c && !cur_c.write) begin
            rdata_q <= mem_q[idx_c];
            ready_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, multi-cycle
// corner sequences and a randomized run against a behavioural memory model.
module tb_dmem_responder;

   localparam int unsigned LAT = 2;
   localparam int unsigned AW  = 10;

   logic        clk = 1'b0;
   logic        rst, rd, wr, stall, rd0, wr0;
   logic [31:0] addr, wdata;
   logic [3:0]  be;
   logic        resp, ready, resp0, ready0;
   logic [31:0] rdata, rdata0;

   always #5 clk = ~clk;

   dmem_responder #(.LATENCY(LAT), .ADDR_WIDTH(AW)) u_dut (
      .clk(clk), .rst(rst), .dmem_read(rd), .dmem_write(wr),
      .dmem_address(addr), .dmem_byte_enable(be), .dmem_wdata(wdata),
      .dmem_stall(stall), .dmem_resp(resp), .dmem_ready(ready), .dmem_rdata(rdata)
   );

   dmem_responder #(.LATENCY(0), .ADDR_WIDTH(AW)) u_dut0 (
      .clk(clk), .rst(rst), .dmem_read(rd0), .dmem_write(wr0),
      .dmem_address(addr), .dmem_byte_enable(be), .dmem_wdata(wdata),
      .dmem_stall(1'b0), .dmem_resp(resp0), .dmem_ready(ready0), .dmem_rdata(rdata0)
   );

   int checks   = 0;
   int failures = 0;

   logic [31:0] mdl_mem [1 << AW];
   logic        mdl_ready = 1'b0;
   logic [31:0] mdl_rdata = '0;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_ready;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference: word index from address bits, byte-lane merge, write wins
   task automatic mdl_apply(input logic r, input logic w, input logic [31:0] a,
                            input logic [3:0] b, input logic [31:0] d);
      int idx;
      idx = int'(a[AW+1:2]);
      if (w) begin
         for (int k = 0; k < 4; k++) if (b[k]) mdl_mem[idx][8*k +: 8] = d[8*k +: 8];
         mdl_ready = 1'b0;
      end else if (r) begin
         mdl_rdata = mdl_mem[idx];
         mdl_ready = 1'b1;
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the access retires
   task automatic access(input logic r, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d, input string tag,
                         output logic obs_ready, output logic [31:0] obs_rdata);
      int n;
      n = 0;
      rd = r; wr = w; addr = a; be = b; wdata = d;
      while (n < 64) begin
         @(negedge clk);
         if (resp === 1'b1) break;
         n++;
      end
      chk({tag, " resp_cycle"}, n, LAT + 1);
      mdl_apply(r, w, a, b, d);
      @(posedge clk); #1;
      rd = 1'b0; wr = 1'b0;
      obs_ready = ready;
      obs_rdata = rdata;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic        o_ready;
      logic [31:0] o_rdata;

      vecs[0] = '{1'b0, 1'b1, 32'h0000_0100, 4'hF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 32'h0000_0100, 4'h0, 32'h0,        32'hDEAD_BEEF, 1'b1};
      vecs[2] = '{1'b0, 1'b1, 32'h0000_0100, 4'h1, 32'h0000_00AA, 32'hDEAD_BEEF, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 32'h0000_0100, 4'h0, 32'h0,        32'hDEAD_BEAA, 1'b1};
      vecs[4] = '{1'b0, 1'b1, 32'h0000_0100, 4'h0, 32'hFFFF_FFFF, 32'hDEAD_BEAA, 1'b0};
      vecs[5] = '{1'b1, 1'b0, 32'h0000_0100, 4'h0, 32'h0,        32'hDEAD_BEAA, 1'b1};
      vecs[6] = '{1'b0, 1'b1, 32'h0000_1000, 4'hF, 32'h1234_5678, 32'hDEAD_BEAA, 1'b0};
      vecs[7] = '{1'b1, 1'b0, 32'h0000_0000, 4'h0, 32'h0,        32'h1234_5678, 1'b1};
      vecs[8] = '{1'b1, 1'b1, 32'h0000_0104, 4'hF, 32'hCAFE_F00D, 32'h1234_5678, 1'b0};
      vecs[9] = '{1'b1, 1'b0, 32'hF000_0107, 4'h0, 32'h0,        32'hCAFE_F00D, 1'b1};

      rst = 1'b1; rd = 1'b0; wr = 1'b0; rd0 = 1'b0; wr0 = 1'b0; stall = 1'b0;
      addr = '0; wdata = '0; be = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Idle after reset: responds every cycle, nothing ready
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("idle_resp", resp, 1'b1);
         chk("reset_ready", ready, 1'b0);
         chk("reset_rdata", rdata, 32'h0);
      end
      @(posedge clk); #1;

      for (int i = 0; i < 10; i++) begin
         access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wdata,
                $sformatf("vec%0d", i), o_ready, o_rdata);
         chk($sformatf("vec%0d_rdata", i), o_rdata, vecs[i].exp_rdata);
         chk($sformatf("vec%0d_ready", i), o_ready, vecs[i].exp_ready);
      end

      // Stall in DONE with the read still held: DONE keeps resp high
      stall = 1'b1; rd = 1'b1; addr = 32'h0000_0100;
      @(negedge clk); chk("stall_c0_resp", resp, 1'b0);
      @(negedge clk); chk("stall_c1_resp", resp, 1'b0);
      @(negedge clk); chk("stall_c2_resp", resp, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); chk("stall_done_resp", resp, 1'b1);
      end
      chk("stall_ready", ready, 1'b1);
      chk("stall_rdata", rdata, 32'hDEAD_BEAA);
      @(posedge clk); #1 stall = 1'b0;
      @(negedge clk); chk("unstall_done_resp", resp, 1'b1);
      @(negedge clk); chk("b2b_accept_resp", resp, 1'b0);
      chk("b2b_idle_ready", ready, 1'b1);
      @(negedge clk); chk("b2b_busy_ready", ready, 1'b0);
      chk("b2b_busy_resp", resp, 1'b0);
      @(negedge clk); chk("b2b_busy2_resp", resp, 1'b0);
      @(negedge clk); chk("b2b_done_resp", resp, 1'b1);
      @(posedge clk); #1 rd = 1'b0;
      mdl_apply(1'b1, 1'b0, 32'h0000_0100, 4'h0, 32'h0);
      chk("b2b_rdata", rdata, 32'hDEAD_BEAA);
      chk("b2b_ready", ready, 1'b1);

      // Reset during BUSY aborts the write
      access(1'b0, 1'b1, 32'h0000_0200, 4'hF, 32'h0, "zero200", o_ready, o_rdata);
      wr = 1'b1; addr = 32'h0000_0200; be = 4'hF; wdata = 32'hFFFF_FFFF;
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk); chk("rst_idle_rule_resp", resp, 1'b0);
      @(posedge clk); #1 rst = 1'b0; wr = 1'b0;
      mdl_ready = 1'b0; mdl_rdata = '0;
      @(negedge clk);
      chk("post_rst_resp", resp, 1'b1);
      chk("post_rst_ready", ready, 1'b0);
      chk("post_rst_rdata", rdata, 32'h0);
      @(posedge clk); #1;
      access(1'b1, 1'b0, 32'h0000_0200, 4'h0, 32'h0, "rd200", o_ready, o_rdata);
      chk("abort_rdata", o_rdata, 32'h0);
      chk("abort_ready", o_ready, 1'b1);

      // Zero-latency instance: resp in cycle 1
      wr0 = 1'b1; addr = 32'h0000_0040; be = 4'hF; wdata = 32'h5A5A_1234;
      @(negedge clk); chk("lat0_wr_c0_resp", resp0, 1'b0);
      @(negedge clk); chk("lat0_wr_c1_resp", resp0, 1'b1);
      @(posedge clk); #1 wr0 = 1'b0; rd0 = 1'b1;
      @(negedge clk); chk("lat0_rd_c0_resp", resp0, 1'b0);
      @(negedge clk); chk("lat0_rd_c1_resp", resp0, 1'b1);
      chk("lat0_rdata", rdata0, 32'h5A5A_1234);
      chk("lat0_ready", ready0, 1'b1);
      @(posedge clk); #1 rd0 = 1'b0;

      // Randomized traffic over 16 words with random aliasing bits
      for (int i = 0; i < 16; i++) begin
         access(1'b0, 1'b1, 32'(i * 4), 4'hF, $urandom, "init", o_ready, o_rdata);
      end
      for (int i = 0; i < 150; i++) begin
         int          op;
         logic [31:0] a;
         op = int'($urandom_range(0, 3));
         a  = ($urandom & 32'hFFFF_F003) | 32'($urandom_range(0, 15) << 2);
         access(op != 2, op >= 2, a, 4'($urandom), $urandom, "rand", o_ready, o_rdata);
         chk("rand_ready", o_ready, mdl_ready);
         chk("rand_rdata", o_rdata, mdl_rdata);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
